// File: rtl/lzrw1_pkg.sv
// Shared types and constants for the LZRW1 decompressor.
//   item_kind_e : kind of compressed item selected by control_word_in
//   state_e     : decompressor FSM states
//   MIN_COPY_LEN/MAX_COPY_LEN : copy length range encoded by the 4-bit length field
//   OFFSET_W/LEN_W            : field widths inside a 16-bit copy item
package lzrw1_pkg;

    typedef enum logic {
        ITEM_LIT  = 1'b0,
        ITEM_COPY = 1'b1
    } item_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EMIT_LIT = 2'd1,
        ST_COPY     = 2'd2
    } state_e;

    localparam int MIN_COPY_LEN = 3;
    localparam int MAX_COPY_LEN = 18;
    localparam int OFFSET_W     = 12;
    localparam int LEN_W        = 4;

    // Remaining-bytes counter width; must hold MAX_COPY_LEN - 1.
    localparam int REM_W        = $clog2(MAX_COPY_LEN);

endpackage

// File: rtl/lzrw1_history_buf.sv
// Circular byte history for the LZRW1 decompressor.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high clear of every slot to 8'h00
//   we/waddr/wdata : single write port
//   raddr/rdata    : combinational read port; a read of the slot being written this
//                    cycle returns the write data so overlapping copies replicate
module lzrw1_history_buf #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    // Next-state of the storage array: one slot updated per write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port with write-to-read forwarding.
    always_comb begin
        if (we && (waddr == raddr)) begin
            rdata = wdata;
        end else begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/lzrw1_decompressor.sv
// Streaming LZRW1-style decompressor: one 16-bit item per handshake, one byte per clock out.
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   data_in            : item; literal byte in [7:0], or copy offset [11:0] and length-3 in [15:12]
//   control_word_in    : 0 = literal, 1 = copy
//   data_in_valid      : item present; taken only while decompressor_busy = 0
//   decompressed_byte  : output byte, qualified by out_valid
//   out_valid          : decompressed_byte valid this cycle
//   decompressor_busy  : item in progress, inputs ignored
//   offset_error       : sticky bad-offset flag, present only when LZRW1_OFFSET_CHECK_EN is defined
// Optional feature macro: LZRW1_OFFSET_CHECK_EN.
//
// Each emitted byte sits in decompressed_byte for one cycle and is written into the
// history at the end of that cycle (write pointer wptr_q). The next copy byte is read in
// that same cycle, so an offset of 1 hits the slot being written and is forwarded.
module lzrw1_decompressor
    import lzrw1_pkg::*;
#(
    parameter int HISTORY_SIZE = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        control_word_in,
    input  logic        data_in_valid,
    output logic [7:0]  decompressed_byte,
    output logic        out_valid,
    output logic        decompressor_busy
`ifdef LZRW1_OFFSET_CHECK_EN
    ,
    output logic        offset_error
`endif
);

    localparam int AW = $clog2(HISTORY_SIZE);

    state_e            state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [7:0]        byte_q, byte_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic              accept_s;
    item_kind_e        kind_s;
    logic [OFFSET_W-1:0] offset_full_s;
    logic [AW-1:0]     offset_s;
    logic [LEN_W-1:0]  len_field_s;
    logic [AW-1:0]     rd_addr_s;
    logic [7:0]        rd_data_s;
    logic              unused_offset_bits_s;

    assign accept_s      = data_in_valid && (state_q == ST_IDLE);
    assign kind_s        = item_kind_e'(control_word_in);
    assign offset_full_s = data_in[OFFSET_W-1:0];
    // Only the low AW offset bits address the history; the rest wrap away.
    assign offset_s      = offset_full_s[AW-1:0];
    assign len_field_s   = data_in[OFFSET_W +: LEN_W];
    assign unused_offset_bits_s = ^offset_full_s;

    // First copy byte is addressed from the live write pointer; later ones from rd_ptr_q.
    always_comb begin
        if (state_q == ST_IDLE) begin
            rd_addr_s = wptr_q - offset_s;
        end else begin
            rd_addr_s = rd_ptr_q;
        end
    end

    lzrw1_history_buf #(
        .DEPTH (HISTORY_SIZE),
        .AW    (AW)
    ) u_hist (
        .clock (clock),
        .reset (reset),
        .we    (out_valid_q),
        .waddr (wptr_q),
        .wdata (byte_q),
        .raddr (rd_addr_s),
        .rdata (rd_data_s)
    );

    // FSM next state, pointers, length counter and next output values.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        rem_d       = rem_q;
        byte_d      = 8'h00;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;

        if (out_valid_q) begin
            wptr_d = wptr_q + AW'(1'b1);
        end else begin
            wptr_d = wptr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    if (kind_s == ITEM_COPY) begin
                        state_d  = ST_COPY;
                        byte_d   = rd_data_s;
                        rd_ptr_d = rd_addr_s + AW'(1'b1);
                        // Bytes still to emit after this one: (field + MIN) - 1.
                        rem_d    = REM_W'(len_field_s) + REM_W'(MIN_COPY_LEN - 1);
                    end else begin
                        state_d  = ST_EMIT_LIT;
                        byte_d   = data_in[7:0];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT_LIT: begin
                state_d = ST_IDLE;
            end
            ST_COPY: begin
                if (rem_q != '0) begin
                    byte_d      = rd_data_s;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    rd_ptr_d    = rd_ptr_q + AW'(1'b1);
                    rem_d       = rem_q - REM_W'(1'b1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Main state and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            rd_ptr_q    <= '0;
            rem_q       <= '0;
            byte_q      <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rem_q       <= rem_d;
            byte_q      <= byte_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign decompressed_byte = byte_q;
    assign out_valid         = out_valid_q;
    assign decompressor_busy = busy_q;

`ifdef LZRW1_OFFSET_CHECK_EN
    logic [AW:0] count_q, count_d;
    logic        err_q, err_d;
    logic [12:0] offset_ext_s;
    logic [12:0] count_ext_s;

    assign offset_ext_s = {1'b0, offset_full_s};
    assign count_ext_s  = 13'(count_q);

    // Saturating bytes-written count and sticky offset error.
    always_comb begin
        if (out_valid_q && (count_q != (AW+1)'(HISTORY_SIZE))) begin
            count_d = count_q + (AW+1)'(1'b1);
        end else begin
            count_d = count_q;
        end

        if (accept_s && (kind_s == ITEM_COPY) &&
            ((offset_ext_s == 13'd0) ||
             (offset_ext_s > count_ext_s) ||
             (offset_ext_s >= 13'(HISTORY_SIZE)))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Offset-check registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign offset_error = err_q;
`endif

endmodule

// File: tb/tb_lzrw1_decompressor.sv
// Self-checking bench for lzrw1_decompressor (HISTORY_SIZE = 256) against a
// queue/array reference model of the LZRW1 decoding rules.
module tb_lzrw1_decompressor;

    localparam int HS = 256;

    logic        clock;
    logic        reset;
    logic [15:0] data_in;
    logic        control_word_in;
    logic        data_in_valid;
    logic [7:0]  decompressed_byte;
    logic        out_valid;
    logic        decompressor_busy;
`ifdef LZRW1_OFFSET_CHECK_EN
    logic        offset_error;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0] m_hist [HS];
    int         m_wptr;
    int         m_count;
    bit         m_err;
    logic [7:0] exp_q [$];

    lzrw1_decompressor #(.HISTORY_SIZE(HS)) dut (
        .clock             (clock),
        .reset             (reset),
        .data_in           (data_in),
        .control_word_in   (control_word_in),
        .data_in_valid     (data_in_valid),
        .decompressed_byte (decompressed_byte),
        .out_valid         (out_valid),
        .decompressor_busy (decompressor_busy)
`ifdef LZRW1_OFFSET_CHECK_EN
        ,
        .offset_error      (offset_error)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < HS; i++) m_hist[i] = 8'h00;
        m_wptr  = 0;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_write(input logic [7:0] b);
        m_hist[m_wptr] = b;
        m_wptr = (m_wptr + 1) % HS;
        if (m_count < HS) m_count++;
    endtask

    // Expected output bytes of one item, applied to the model history.
    task automatic model_item(input logic ctrl, input logic [15:0] d);
        int off;
        int len;
        logic [7:0] b;
        exp_q.delete();
        if (!ctrl) begin
            exp_q.push_back(d[7:0]);
            model_write(d[7:0]);
        end else begin
            off = int'(d[11:0]);
            len = int'(d[15:12]) + 3;
            if (off == 0 || off > m_count || off >= HS) m_err = 1'b1;
            for (int k = 0; k < len; k++) begin
                b = m_hist[(m_wptr - (off % HS) + HS) % HS];
                exp_q.push_back(b);
                model_write(b);
            end
        end
    endtask

    task automatic check_err(input string tag);
`ifdef LZRW1_OFFSET_CHECK_EN
        check_value(tag, 32'(offset_error), 32'(m_err));
`else
        check_value(tag, 32'(decompressor_busy), 32'(1'b0));
`endif
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        data_in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check_value("rst_valid", 32'(out_valid), 32'd0);
        check_value("rst_busy", 32'(decompressor_busy), 32'd0);
        check_value("rst_byte", 32'(decompressed_byte), 32'd0);
        reset = 1'b0;
        model_reset();
        check_err("rst_err");
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (decompressor_busy && guard < 64) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 64) check_value("busy_timeout", 32'd1, 32'd0);
    endtask

    // Drive one item at a negedge, then check every output cycle plus the idle cycle.
    task automatic send_item(input logic ctrl, input logic [15:0] d);
        wait_idle();
        model_item(ctrl, d);
        control_word_in = ctrl;
        data_in = d;
        data_in_valid = 1'b1;
        @(posedge clock);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clock);
            check_value("emit_valid", 32'(out_valid), 32'd1);
            check_value("emit_busy", 32'(decompressor_busy), 32'd1);
            check_value("emit_byte", 32'(decompressed_byte), 32'(exp_q[k]));
            // noise while busy must be ignored
            data_in_valid = 1'($urandom_range(0, 1));
            control_word_in = 1'($urandom_range(0, 1));
            data_in = 16'($urandom);
        end
        @(negedge clock);
        data_in_valid = 1'b0;
        check_value("done_valid", 32'(out_valid), 32'd0);
        check_value("done_busy", 32'(decompressor_busy), 32'd0);
        check_err("offset_err");
    endtask

    initial begin
        reset = 1'b1;
        data_in = 16'h0000;
        control_word_in = 1'b0;
        data_in_valid = 1'b0;
        model_reset();
        do_reset();

        // literals then overlapping / non-overlapping copies
        send_item(1'b0, 16'h0041);
        send_item(1'b0, 16'h0042);
        send_item(1'b1, 16'h1002);
        do_reset();
        send_item(1'b0, 16'h0041);
        send_item(1'b1, 16'h2001);

        // offset beyond written data and its stickiness
        do_reset();
        send_item(1'b0, 16'h0061);
        send_item(1'b0, 16'h0062);
        send_item(1'b1, 16'h0005);
        send_item(1'b0, 16'h0063);
        send_item(1'b1, 16'h0001);

        // wrap-around with a 256-byte history
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send_item(1'b0, {8'($urandom), 8'(i % 256)});
        end
        send_item(1'b1, 16'h0100);
        send_item(1'b1, 16'h00FF);
        send_item(1'b1, 16'hF000);

        // reset on the 5th output cycle of an 18-byte copy
        wait_idle();
        model_item(1'b1, 16'hF003);
        control_word_in = 1'b1;
        data_in = 16'hF003;
        data_in_valid = 1'b1;
        @(posedge clock);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            data_in_valid = 1'b0;
            check_value("abort_byte", 32'(decompressed_byte), 32'(exp_q[k]));
            check_value("abort_valid", 32'(out_valid), 32'd1);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_value("abort_after_valid", 32'(out_valid), 32'd0);
        check_value("abort_after_busy", 32'(decompressor_busy), 32'd0);
        @(negedge clock);
        check_value("abort_idle_valid", 32'(out_valid), 32'd0);
        send_item(1'b1, 16'h2007);
        send_item(1'b0, 16'h0011);

        // random items
        for (int n = 0; n < 300; n++) begin
            send_item(1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
